// File: rtl/s444_cfg_loader.sv
// Byte-stream to scan-chain configuration loader for the S444 logic cell.
// Optional readback CRC check is enabled by defining S444_CFG_READBACK_EN.
module s444_cfg_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       cfg_shift_in,
    output logic       cfg_en,
    input  logic       cfg_shift_out,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_SHIFT  = 3'd2,
`ifdef S444_CFG_READBACK_EN
        S_VERIFY = 3'd3,
`endif
        S_DONE   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bitidx;
    logic [7:0]       r_shreg;
    logic             r_shift_in;
    logic             r_en;
    logic             w_accept;
    logic             w_begin;
    logic             w_last_bit;
    logic             w_byte_end;

    assign w_last_bit = (r_cnt == LAST_BIT);
    assign w_byte_end = (r_bitidx == 3'd7);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        w_accept = 1'b0;
        w_begin  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next  = S_WAIT;
                    w_begin = 1'b1;
                end
            end
            S_WAIT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next   = S_SHIFT;
                    w_accept = 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_last_bit) begin
`ifdef S444_CFG_READBACK_EN
                    w_next = S_VERIFY;
`else
                    w_next = S_DONE;
`endif
                end else if (w_byte_end) begin
                    w_next = S_WAIT;
                end
            end
`ifdef S444_CFG_READBACK_EN
            S_VERIFY: begin
                if (w_last_bit) begin
                    w_next = S_DONE;
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
        // abort overrides every other event, including a byte offered this cycle
        if (abort) begin
            w_next   = S_IDLE;
            in_ready = 1'b0;
            w_accept = 1'b0;
            w_begin  = 1'b0;
        end
    end

`ifdef S444_CFG_READBACK_EN
    logic [7:0] r_crc_tx;
    logic [7:0] r_crc_rx;
    logic       r_error;

    function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt      <= '0;
            r_bitidx   <= '0;
            r_shift_in <= 1'b0;
            r_en       <= 1'b0;
`ifdef S444_CFG_READBACK_EN
            r_crc_tx   <= '0;
            r_crc_rx   <= '0;
            r_error    <= 1'b0;
`endif
        end else begin
            r_en <= (w_next == S_SHIFT)
`ifdef S444_CFG_READBACK_EN
                    || (w_next == S_VERIFY)
`endif
                    ;
            if (w_accept) begin
                r_shreg    <= in_data;
                r_shift_in <= in_data[0];
                r_bitidx   <= '0;
            end
            // r_shift_in is the bit on the pins this cycle; preload the next one
            if (r_state == S_SHIFT) begin
                r_shreg    <= r_shreg >> 1;
                r_shift_in <= r_shreg[1];
                r_bitidx   <= r_bitidx + 3'd1;
                r_cnt      <= w_last_bit ? '0 : r_cnt + 1'b1;
`ifdef S444_CFG_READBACK_EN
                r_crc_tx   <= crc8_upd(r_crc_tx, r_shift_in);
`endif
            end
`ifdef S444_CFG_READBACK_EN
            if (r_state == S_VERIFY) begin
                r_crc_rx <= crc8_upd(r_crc_rx, cfg_shift_out);
                r_cnt    <= r_cnt + 1'b1;
                if (w_last_bit) begin
                    r_error <= (r_crc_tx != crc8_upd(r_crc_rx, cfg_shift_out));
                end
            end
`endif
            if (w_begin) begin
                r_cnt    <= '0;
                r_bitidx <= '0;
`ifdef S444_CFG_READBACK_EN
                r_crc_tx <= '0;
                r_crc_rx <= '0;
                r_error  <= 1'b0;
`endif
            end
`ifdef S444_CFG_READBACK_EN
            if (abort) begin
                r_error <= 1'b0;
            end
`endif
        end
    end

    assign cfg_en = r_en;
    assign busy   = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done   = (r_state == S_DONE);

`ifdef S444_CFG_READBACK_EN
    // VERIFY recirculates the chain output straight back into its input
    assign cfg_shift_in = (r_state == S_VERIFY) ? cfg_shift_out : r_shift_in;
    assign error        = r_error;
`else
    logic w_unused_shift_out;
    assign w_unused_shift_out = cfg_shift_out;
    assign cfg_shift_in       = r_shift_in;
    assign error              = 1'b0;
`endif

endmodule

// File: tb/tb_s444_cfg_loader.sv
// Self-checking bench for s444_cfg_loader with a behavioural scan-chain model;
// covers both builds (S444_CFG_READBACK_EN defined or not).
module tb_s444_cfg_loader;

    localparam int CL = 12;
    localparam int NB = (CL + 7) / 8;
`ifdef S444_CFG_READBACK_EN
    localparam int MULT = 2;
`else
    localparam int MULT = 1;
`endif

    logic       clock;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       cfg_shift_in;
    logic       cfg_en;
    logic       cfg_shift_out;
    logic       busy;
    logic       done;
    logic       error;

    int errors = 0;
    int checks = 0;

    s444_cfg_loader #(.CHAIN_LEN(CL), .CNT_W(12)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cfg_shift_in (cfg_shift_in),
        .cfg_en       (cfg_en),
        .cfg_shift_out(cfg_shift_out),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural scan chain: shifts toward index 0 whenever cfg_en is high
    logic [CL-1:0] chain;
    logic [CL-1:0] chain_in;
    logic          corrupt;
    assign chain_in      = corrupt ? (chain ^ (CL'(1) << 7)) : chain;
    assign cfg_shift_out = chain[0];
    always @(posedge clock) begin
        if (cfg_en) chain <= {cfg_shift_in, chain_in[CL-1:1]};
        else        chain <= chain_in;
    end

    // Recorder of every bit presented while cfg_en is high, plus idle gaps while busy
    logic clr;
    bit   bits_q[$];
    int   gaps_q[$];
    int   cur_gap;
    always @(posedge clock) begin
        if (clr) begin
            bits_q.delete();
            gaps_q.delete();
            cur_gap <= 0;
        end else if (cfg_en) begin
            bits_q.push_back(cfg_shift_in);
            if (cur_gap > 0) gaps_q.push_back(cur_gap);
            cur_gap <= 0;
        end else if (busy) begin
            cur_gap <= cur_gap + 1;
        end
    end

    logic [7:0] cur_bytes [NB];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Chain order: bit i of the stream is byte i/8, bit i%8 (LSB first)
    function automatic logic [CL-1:0] model_vec();
        logic [CL-1:0] v;
        for (int i = 0; i < CL; i++) v[i] = cur_bytes[i / 8][i % 8];
        return v;
    endfunction

    function automatic logic [CL-1:0] rec_vec(input int off);
        logic [CL-1:0] v;
        for (int i = 0; i < CL; i++) v[i] = (off + i < bits_q.size()) ? bits_q[off + i] : 1'b0;
        return v;
    endfunction

    task automatic clear_rec();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic run_load(input string tag, input int stall, input int start_at, input bit do_corrupt);
        int idx = 0;
        int stall_left = 0;
        int cyc = 0;
        int extra_ready = 0;
        int ready_stall = 0;
        bit corrupted = 0;
        bit rdy;
        bit acc;
        clear_rec();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_after_start"}, busy, 1);
        while (!done && cyc < 300) begin
            in_valid = (stall_left == 0);
            in_data  = cur_bytes[(idx < NB) ? idx : NB - 1];
            start    = (cyc == start_at);
            corrupt  = do_corrupt && !corrupted && (bits_q.size() == CL);
            if (corrupt) corrupted = 1;
            #1;
            rdy = in_ready;
            acc = in_valid && in_ready;
            if (idx >= NB && rdy) extra_ready++;
            if (!in_valid && rdy) ready_stall++;
            tick();
            cyc++;
            if (acc) begin
                idx++;
                if (idx == 1) stall_left = stall;
            end else if (rdy && stall_left > 0) begin
                stall_left--;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        corrupt  = 1'b0;
        chk({tag, "_cycles"}, cyc, NB + stall + MULT * CL);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_en_low"}, cfg_en, 0);
        chk({tag, "_en_count"}, bits_q.size(), MULT * CL);
        chk({tag, "_bytes_taken"}, idx, NB);
        chk({tag, "_extra_ready"}, extra_ready, 0);
        chk({tag, "_ready_in_stall"}, ready_stall, stall);
        chk({tag, "_bits"}, 32'(rec_vec(0)), 32'(model_vec()));
        chk({tag, "_gap_count"}, gaps_q.size(), NB);
        if (gaps_q.size() == NB) chk({tag, "_gap_last"}, gaps_q[NB - 1], 1 + stall);
        if (!corrupted) chk({tag, "_chain"}, 32'(chain), 32'(model_vec()));
`ifdef S444_CFG_READBACK_EN
        chk({tag, "_error"}, error, do_corrupt);
        if (!do_corrupt) chk({tag, "_readback"}, 32'(rec_vec(CL)), 32'(model_vec()));
`else
        chk({tag, "_error"}, error, 0);
`endif
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        clr = 1'b0; corrupt = 1'b0; chain = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_shift_in", cfg_shift_in, 0);
        chk("rst_en", cfg_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);

        cur_bytes[0] = 8'hA5; cur_bytes[1] = 8'h3C;
        run_load("a5_3c", 0, -1, 0);
        chk("a5_3c_literal", 32'(rec_vec(0)), 32'h0CA5);

        cur_bytes[0] = 8'hFF; cur_bytes[1] = 8'h5A;
        run_load("ff_5a", 0, -1, 0);
        chk("ff_5a_literal", 32'(rec_vec(0)), 32'h0AFF);

        run_load("stall5", 5, -1, 0);
        run_load("start_mid", 0, 3, 0);

        for (int n = 0; n < 6; n++) begin
            cur_bytes[0] = 8'($urandom);
            cur_bytes[1] = 8'($urandom);
            run_load("rand", $urandom_range(0, 6), ($urandom_range(0, 1) == 1) ? 4 : -1, 0);
        end

`ifdef S444_CFG_READBACK_EN
        cur_bytes[0] = 8'h96; cur_bytes[1] = 8'h0E;
        run_load("corrupt", 0, -1, 1);
`endif

        // abort while done is held
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done_done", done, 0);
        chk("abort_done_busy", busy, 0);

        // abort on the third shift cycle
        clear_rec();
        in_data = 8'hC3; in_valid = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_shift_busy", busy, 0);
        chk("abort_shift_done", done, 0);
        chk("abort_shift_en", cfg_en, 0);
        chk("abort_shift_ready", in_ready, 0);
        chk("abort_shift_nbits", bits_q.size(), 3);
        chk("abort_shift_bits", 32'(rec_vec(0)) & 32'h7, 32'h3);
        in_valid = 1'b0;

        // abort with a byte offered in WAIT_BYTE
        clear_rec();
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; abort = 1'b1;
        #1;
        chk("abort_wait_ready", in_ready, 0);
        tick();
        abort = 1'b0;
        tick();
        chk("abort_wait_busy", busy, 0);
        chk("abort_wait_nbits", bits_q.size(), 0);
        in_valid = 1'b0;

        // reset in the middle of SHIFT
        in_valid = 1'b1; in_data = 8'hFF;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_mid_in_ready", in_ready, 0);
        chk("rst_mid_shift_in", cfg_shift_in, 0);
        chk("rst_mid_en", cfg_en, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_error", error, 0);
        in_valid = 1'b0;
        tick();

        cur_bytes[0] = 8'h61; cur_bytes[1] = 8'h07;
        run_load("after_rst", 2, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/s444_cfg_loader.md
Name: s444_cfg_loader

Overview:
- Upstream configuration stage for the S444 logic cell.
- Accepts a configuration bitstream as a byte stream using a valid/ready handshake.
- Serialises the stream into the cell's scan chain, one bit per clock, driving the cell's shift_in and en pins.
- Reports load completion and, optionally, the result of a readback integrity check that uses the cell's shift_out pin.

Parameters:
- CHAIN_LEN, 64: number of bits in the cell scan chain (legal range 1..4095).
- CNT_W, 12: width of the bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE or DONE.
- abort  in  1  aborts an in-progress load or verify; the loader returns to IDLE.
- in_data  in  8  configuration byte, shifted LSB first.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data this cycle.
- cfg_shift_in  out  1  serial bit to the cell's shift_in.
- cfg_en  out  1  chain shift enable to the cell's en; the cell shifts on every edge where this is high.
- cfg_shift_out  in  1  serial bit returned from the cell's shift_out.
- busy  out  1  high in any state other than IDLE and DONE.
- done  out  1  level; high in DONE, cleared by start or abort.
- error  out  1  level; valid while done=1.

Behaviour:
- Reset values: in_ready=0, cfg_shift_in=0, cfg_en=0, busy=0, done=0, error=0; state=IDLE; counters and CRCs cleared. Scan chain contents after reset are undefined.
- States: IDLE, WAIT_BYTE, SHIFT, VERIFY (present only when the macro is defined), DONE.
- IDLE or DONE + start → WAIT_BYTE. Also clears done, error, bit counter and CRCs.
- WAIT_BYTE:
  - in_ready=1.
  - On in_valid & in_ready, the byte is captured into an 8-bit shift register → SHIFT.
  - cfg_en=0 in this state, so every byte boundary costs one bubble cycle.
- SHIFT:
  - Each cycle: cfg_en=1, cfg_shift_in = shreg[0]; shreg shifts right; the bit counter increments.
  - After 8 bits, or when the bit counter reaches CHAIN_LEN, the FSM leaves SHIFT.
  - Exit target: WAIT_BYTE if bits remain; otherwise DONE, or VERIFY when the macro is defined.
- Partial final byte: when CHAIN_LEN mod 8 = r ≠ 0, only bits [r-1:0] of the last byte are shifted. The upper bits are discarded and no extra byte is requested.
- cfg_en and cfg_shift_in are registered outputs; they change only at clock edges. cfg_en is high for exactly CHAIN_LEN cycles per load, excluding verify.
- Backpressure: while in WAIT_BYTE with in_valid=0, the loader stalls with cfg_en=0. There is no timeout.
- start while busy=1 is ignored.
- abort wins over every other event in the same cycle:
  - Next cycle: IDLE, cfg_en=0, done=0, error=0.
  - A byte offered in the same cycle is not accepted (in_ready forced 0).
  - Chain contents are left partially loaded.
- reset mid-operation: same effect as abort, plus all counters are cleared.
- Without the macro: error is tied to 0, and DONE is entered the cycle after the last shift.

Optional Feature:
- Macro: S444_CFG_READBACK_EN.
- When defined:
  - CRC-8 (poly x^8+x^2+x+1, init 0x00, MSB-first update) is computed over every bit driven on cfg_shift_in during SHIFT.
  - VERIFY then runs for CHAIN_LEN cycles with cfg_en=1 and cfg_shift_in = cfg_shift_out. This recirculates the chain, so contents are preserved.
  - A second CRC-8 is computed over cfg_shift_out during VERIFY.
  - At the end of VERIFY → DONE, with error=1 iff the two CRCs differ.
  - Total cfg_en-high cycles per load = 2*CHAIN_LEN.
- When undefined: no VERIFY state, no CRC logic, error=0.

Test Plan:
- CHAIN_LEN=16; start; bytes 0xA5 then 0x3C, with in_valid held high → cfg_shift_in over the cfg_en-high cycles = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0. cfg_en is high for exactly 16 cycles with one bubble between the bytes. done=1 and busy=0 one cycle after the last shift.
- CHAIN_LEN=12; bytes 0xFF, 0x5A → 8 ones, then 0,1,0,1. Only 2 bytes are requested; in_ready=0 after the second byte is accepted.
- Backpressure: in_valid dropped for 5 cycles between the bytes → cfg_en=0 for 6 cycles (5 stall cycles plus the bubble), in_ready=1 throughout the stall, and the bit sequence is unchanged.
- start pulsed mid-SHIFT is ignored (no counter reset). abort on the 3rd shift cycle → next cycle IDLE, cfg_en=0, done=0. reset mid-SHIFT → all outputs 0 next cycle.
- With S444_CFG_READBACK_EN and a 16-bit behavioural chain model:
  - Intact chain → done=1, error=0, 32 cfg_en cycles, and the model contents equal the loaded data.
  - Model bit 7 forced inverted during VERIFY → done=1, error=1.
